gpio_debounce: RTL and testbench
================================

Name: gpio_debounce

Overview:
- Input conditioning stage between the bidirectional GPIO pads and the port-A input of the GPIO controller.
- Synchronises each pad input into pclk, then applies a per-pin programmable debounce filter.
- Delivers filtered levels plus one-cycle rise/fall pulses to the controller's external-port input and its edge-detect logic.
- Threshold, prescale and per-pin enable are static configuration driven from the APB register block.

Parameters:
- PIN_NUM, 8, number of port-A pins filtered.
- CNT_W, 8, width of debounce threshold and per-pin counters.
- PRE_W, 16, width of the shared tick prescaler.

Ports:
- pclk  input  1  APB/peripheral clock; the only clock.
- preset  input  1  synchronous, active-high reset.
- pad_in  input  PIN_NUM  raw pad levels, asynchronous to pclk.
- db_en  input  PIN_NUM  per-pin filter enable; 0 = bypass (synchroniser only).
- db_cnt  input  CNT_W  stable-tick threshold N; a change is accepted after N+1 consecutive differing ticks.
- db_pre  input  PRE_W  prescale P; one filter tick every P+1 pclk cycles.
- ext_porta  output  PIN_NUM  filtered pin level, to controller external-port input.
- porta_rise  output  PIN_NUM  one-cycle pulse when ext_porta bit goes 0->1.
- porta_fall  output  PIN_NUM  one-cycle pulse when ext_porta bit goes 1->0.
- db_busy  output  PIN_NUM  1 while a pin's synced level differs from ext_porta (change pending).

Behaviour:
- Reset: clock is one pclk domain; reset is synchronous, active-high (preset sampled on rising pclk). All synchroniser flops, prescaler, counters, ext_porta, porta_rise, porta_fall and db_busy reset to 0. Reset asserted mid-filter discards any pending count.
- Synchroniser: two-flop chain per pin, sync2 = output.
- Prescaler: pre_cnt counts 0..db_pre.
  - tick = (pre_cnt >= db_pre); on tick, pre_cnt <= 0, else pre_cnt + 1.
  - P = 0 gives a tick every cycle.
  - Lowering db_pre below pre_cnt forces a tick and wrap on the next cycle.
- Per-pin filter, state s (= ext_porta bit) and counter c:
  - db_en = 0: s <= sync2 every cycle, c <= 0.
  - db_en = 1, sync2 == s: c <= 0 (any glitch restarts the count).
  - db_en = 1, sync2 != s, no tick: hold.
  - db_en = 1, sync2 != s, tick, c >= db_cnt: s <= sync2, c <= 0.
  - db_en = 1, sync2 != s, tick, c < db_cnt: c <= c + 1.
  - The c >= db_cnt compare covers db_cnt being lowered mid-count. c never exceeds 2^CNT_W - 1 and does not wrap.
- Edges: porta_rise/porta_fall are registered and asserted in the same cycle ext_porta first shows the new value, for exactly one cycle. Both pulses are never high together on one pin.
- db_busy = registered (sync2 != s), updated each cycle.
- Latency, pad change to ext_porta:
  - Bypass: 3 cycles.
  - Filtered, P = 0: 3 + N cycles.
  - Filtered, general P: between N*(P+1)+3 and (N+1)*(P+1)+2 cycles.
- db_en toggled 1->0 mid-count: the pin takes sync2 next cycle and c clears. Toggled 0->1: filtering starts from the current s.
- Reset release with pad held high: ext_porta rises after the normal filter latency and porta_rise pulses once.

Decomposition:
- Shared package gpio_pkg holds:
  - constants GPIO_PIN_NUM = 8, GPIO_DB_CNT_W = 8, GPIO_DB_PRE_W = 16;
  - a packed struct for the per-pin config (en).
- Natural sub-module: gpio_db_cell, one pin covering synchroniser, counter, state and edge pulses, with tick as input. It is instantiated PIN_NUM times.
- Prescaler stays in the top.

Test Plan:
- Bypass: db_en=0x00; pad_in 0x00->0xA5 -> ext_porta = 0xA5 exactly 3 cycles later; porta_rise = 0xA5 for one cycle; porta_fall = 0x00.
- Filter, P=0, N=4: db_en=0x01; pad_in[0] 0->1 held -> ext_porta[0] = 1 at cycle 7; porta_rise[0] pulses at cycle 7; db_busy[0] high cycles 3-6.
- Glitch reject: P=0, N=4; pad_in[0] high for 4 cycles then low -> ext_porta[0] stays 0, no pulses, db_busy[0] returns to 0.
- Prescale: P=9, N=2; pad_in[3] 0->1 held -> ext_porta[3] = 1 within cycles 23..32; change db_pre 9->0 mid-count -> tick next cycle.
- Reset mid-count: P=0, N=10; assert preset at cycle 6 for 1 cycle with pad held 1 -> all outputs 0 the cycle after; ext_porta[0] = 1 at 13 cycles after release.
- Enable drop: N=200 count in progress, db_en 1->0 -> ext_porta follows sync2 next cycle, porta_rise pulses once, db_busy clears.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO port-A input conditioning path.
package gpio_pkg;

  localparam int GPIO_PIN_NUM  = 8;
  localparam int GPIO_DB_CNT_W = 8;
  localparam int GPIO_DB_PRE_W = 16;

  typedef struct packed {
    logic en;
  } db_cfg_t;

endpackage

// File: rtl/gpio_db_cell.sv
// One pad: two-flop synchroniser, tick-driven debounce counter, filtered level
// and registered rise/fall/busy flags.
module gpio_db_cell
  import gpio_pkg::*;
#(
  parameter int CNT_W = GPIO_DB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad,
  input  db_cfg_t          cfg,
  input  logic             tick,
  input  logic [CNT_W-1:0] thresh,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             busy
);

  logic             sync1, sync2;
  logic             s, s_nxt;
  logic [CNT_W-1:0] c, c_nxt;

  // c only increments while below thresh, so it can never wrap.
  always_comb begin
    s_nxt = s;
    c_nxt = c;
    if (!cfg.en) begin
      s_nxt = sync2;
      c_nxt = '0;
    end else if (sync2 == s) begin
      c_nxt = '0;
    end else if (tick) begin
      if (c >= thresh) begin
        s_nxt = sync2;
        c_nxt = '0;
      end else begin
        c_nxt = c + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      s     <= 1'b0;
      c     <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      s     <= s_nxt;
      c     <= c_nxt;
      rise  <= s_nxt & ~s;
      fall  <= ~s_nxt & s;
      // Compared against the next state so busy drops with the accepting edge.
      busy  <= (sync2 != s_nxt);
    end
  end

  assign level = s;

endmodule

// File: rtl/gpio_debounce.sv
// Port-A input conditioning: shared tick prescaler plus one debounce cell per pin.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int PIN_NUM = GPIO_PIN_NUM,
  parameter int CNT_W   = GPIO_DB_CNT_W,
  parameter int PRE_W   = GPIO_DB_PRE_W
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [PIN_NUM-1:0] pad_in,
  input  logic [PIN_NUM-1:0] db_en,
  input  logic [CNT_W-1:0]   db_cnt,
  input  logic [PRE_W-1:0]   db_pre,
  output logic [PIN_NUM-1:0] ext_porta,
  output logic [PIN_NUM-1:0] porta_rise,
  output logic [PIN_NUM-1:0] porta_fall,
  output logic [PIN_NUM-1:0] db_busy
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  // ">=" rather than "==" so lowering db_pre below pre_cnt wraps at once.
  assign tick = (pre_cnt >= db_pre);

  always_ff @(posedge pclk) begin
    if (preset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < PIN_NUM; i++) begin : g_pin
    db_cfg_t cfg;
    assign cfg.en = db_en[i];

    gpio_db_cell #(.CNT_W(CNT_W)) u_cell (
      .clk    (pclk),
      .rst    (preset),
      .pad    (pad_in[i]),
      .cfg    (cfg),
      .tick   (tick),
      .thresh (db_cnt),
      .level  (ext_porta[i]),
      .rise   (porta_rise[i]),
      .fall   (porta_fall[i]),
      .busy   (db_busy[i])
    );
  end

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce: expectations are queued with cycle windows
// as stimulus is driven and retired by a monitor sampling just after each falling edge.
module tb_gpio_debounce;

  localparam int S_EXT  = 0;
  localparam int S_RISE = 1;
  localparam int S_FALL = 2;
  localparam int S_BUSY = 3;

  logic        pclk = 1'b0;
  logic        preset;
  logic [7:0]  pad_in;
  logic [7:0]  db_en;
  logic [7:0]  db_cnt;
  logic [15:0] db_pre;
  logic [7:0]  ext_porta;
  logic [7:0]  porta_rise;
  logic [7:0]  porta_fall;
  logic [7:0]  db_busy;

  gpio_debounce dut (
    .pclk       (pclk),
    .preset     (preset),
    .pad_in     (pad_in),
    .db_en      (db_en),
    .db_cnt     (db_cnt),
    .db_pre     (db_pre),
    .ext_porta  (ext_porta),
    .porta_rise (porta_rise),
    .porta_fall (porta_fall),
    .db_busy    (db_busy)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // hold=1: value must match on every cycle of [lo,hi]; hold=0: must match on some cycle.
  typedef struct {
    string    tag;
    int       sel;
    logic [7:0] mask;
    logic [7:0] val;
    int       lo;
    int       hi;
    bit       hold;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at cycle %0d", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [7:0] pick(input int sel);
    case (sel)
      S_EXT:   pick = ext_porta;
      S_RISE:  pick = porta_rise;
      S_FALL:  pick = porta_fall;
      default: pick = db_busy;
    endcase
  endfunction

  task automatic sb_push(input string tag, input int sel, input logic [7:0] mask,
                         input logic [7:0] val, input int lo, input int hi, input bit hold);
    exp_t e;
    e.tag = tag; e.sel = sel; e.mask = mask; e.val = val;
    e.lo = lo; e.hi = hi; e.hold = hold;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  always @(negedge pclk) begin
    exp_t       e;
    logic [7:0] o;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      e = sb[i];
      o = pick(e.sel) & e.mask;
      if (cyc >= e.lo && cyc <= e.hi) begin
        if (e.hold) begin
          if (o !== e.val || cyc == e.hi) begin
            chk(e.tag, o, e.val);
            sb.delete(i);
          end
        end else if (o === e.val || cyc == e.hi) begin
          chk(e.tag, o, e.val);
          sb.delete(i);
        end
      end
    end
  end

  int t0;

  initial begin
    preset = 1'b1;
    pad_in = 8'h00;
    db_en  = 8'h00;
    db_cnt = 8'd0;
    db_pre = 16'd0;
    step(3);
    sb_push("rst_ext",  S_EXT,  8'hFF, 8'h00, cyc + 1, cyc + 1, 1'b1);
    sb_push("rst_rise", S_RISE, 8'hFF, 8'h00, cyc + 1, cyc + 1, 1'b1);
    sb_push("rst_fall", S_FALL, 8'hFF, 8'h00, cyc + 1, cyc + 1, 1'b1);
    sb_push("rst_busy", S_BUSY, 8'hFF, 8'h00, cyc + 1, cyc + 1, 1'b1);
    step(2);
    preset = 1'b0;
    step(4);

    // Bypass: three-cycle synchroniser path
    t0 = cyc;
    pad_in = 8'hA5;
    sb_push("byp_ext_early", S_EXT,  8'hFF, 8'h00, t0 + 2, t0 + 2, 1'b1);
    sb_push("byp_ext",       S_EXT,  8'hFF, 8'hA5, t0 + 3, t0 + 3, 1'b1);
    sb_push("byp_rise",      S_RISE, 8'hFF, 8'hA5, t0 + 3, t0 + 3, 1'b1);
    sb_push("byp_rise_end",  S_RISE, 8'hFF, 8'h00, t0 + 4, t0 + 4, 1'b1);
    sb_push("byp_no_fall",   S_FALL, 8'hFF, 8'h00, t0 + 1, t0 + 5, 1'b1);
    sb_push("byp_no_busy",   S_BUSY, 8'hFF, 8'h00, t0 + 1, t0 + 5, 1'b1);
    step(8);
    t0 = cyc;
    pad_in = 8'h00;
    sb_push("byp_fall",      S_FALL, 8'hFF, 8'hA5, t0 + 3, t0 + 3, 1'b1);
    step(6);

    // Filter P=0 N=4 on pin 0
    db_en = 8'h01; db_cnt = 8'd4; db_pre = 16'd0;
    step(2);
    t0 = cyc;
    pad_in = 8'h01;
    sb_push("flt_ext_hold",  S_EXT,  8'h01, 8'h00, t0 + 1, t0 + 6, 1'b1);
    sb_push("flt_ext",       S_EXT,  8'h01, 8'h01, t0 + 7, t0 + 7, 1'b1);
    sb_push("flt_rise",      S_RISE, 8'h01, 8'h01, t0 + 7, t0 + 7, 1'b1);
    sb_push("flt_rise_end",  S_RISE, 8'h01, 8'h00, t0 + 8, t0 + 8, 1'b1);
    sb_push("flt_busy_pre",  S_BUSY, 8'h01, 8'h00, t0 + 2, t0 + 2, 1'b1);
    sb_push("flt_busy",      S_BUSY, 8'h01, 8'h01, t0 + 3, t0 + 6, 1'b1);
    sb_push("flt_busy_end",  S_BUSY, 8'h01, 8'h00, t0 + 7, t0 + 7, 1'b1);
    step(10);
    pad_in = 8'h00;
    step(12);

    // Glitch of four cycles is rejected
    t0 = cyc;
    pad_in = 8'h01;
    sb_push("gl_ext",      S_EXT,  8'h01, 8'h00, t0 + 1, t0 + 15, 1'b1);
    sb_push("gl_no_rise",  S_RISE, 8'h01, 8'h00, t0 + 1, t0 + 15, 1'b1);
    sb_push("gl_no_fall",  S_FALL, 8'h01, 8'h00, t0 + 1, t0 + 15, 1'b1);
    sb_push("gl_busy_on",  S_BUSY, 8'h01, 8'h01, t0 + 3, t0 + 6, 1'b1);
    sb_push("gl_busy_off", S_BUSY, 8'h01, 8'h00, t0 + 7, t0 + 12, 1'b1);
    step(4);
    pad_in = 8'h00;
    step(12);

    // Prescale P=9 N=2 on pin 3
    db_en = 8'h08; db_cnt = 8'd2; db_pre = 16'd9;
    step(2);
    t0 = cyc;
    pad_in = 8'h08;
    sb_push("pre_ext_hold", S_EXT, 8'h08, 8'h00, t0 + 1, t0 + 22, 1'b1);
    sb_push("pre_ext",      S_EXT, 8'h08, 8'h08, t0 + 23, t0 + 32, 1'b0);
    step(34);
    // Lowering db_pre mid-count forces ticks every cycle from the next edge
    t0 = cyc;
    pad_in = 8'h00;
    sb_push("pre_fall_hold", S_EXT,  8'h08, 8'h08, t0 + 1, t0 + 6, 1'b1);
    sb_push("pre_busy",      S_BUSY, 8'h08, 8'h08, t0 + 3, t0 + 5, 1'b1);
    sb_push("pre_fall_fast", S_EXT,  8'h08, 8'h00, t0 + 7, t0 + 8, 1'b0);
    step(5);
    db_pre = 16'd0;
    step(8);

    // Reset mid-count discards the pending count
    db_en = 8'h01; db_cnt = 8'd10; db_pre = 16'd0;
    step(2);
    t0 = cyc;
    pad_in = 8'h01;
    step(6);
    preset = 1'b1;
    sb_push("mrst_ext",  S_EXT,  8'hFF, 8'h00, t0 + 7, t0 + 7, 1'b1);
    sb_push("mrst_rise", S_RISE, 8'hFF, 8'h00, t0 + 7, t0 + 7, 1'b1);
    sb_push("mrst_fall", S_FALL, 8'hFF, 8'h00, t0 + 7, t0 + 7, 1'b1);
    sb_push("mrst_busy", S_BUSY, 8'hFF, 8'h00, t0 + 7, t0 + 7, 1'b1);
    step(1);
    preset = 1'b0;
    sb_push("mrst_ext_hold", S_EXT,  8'h01, 8'h00, t0 + 8, t0 + 19, 1'b1);
    sb_push("mrst_ext_up",   S_EXT,  8'h01, 8'h01, t0 + 20, t0 + 20, 1'b1);
    sb_push("mrst_rise_up",  S_RISE, 8'h01, 8'h01, t0 + 20, t0 + 20, 1'b1);
    step(24);

    // Enable drop mid-count on pin 5 with N=200
    db_en = 8'h20; db_cnt = 8'd200;
    step(2);
    t0 = cyc;
    pad_in = 8'h21;
    sb_push("en_ext_hold", S_EXT,  8'h20, 8'h00, t0 + 1, t0 + 20, 1'b1);
    sb_push("en_busy",     S_BUSY, 8'h20, 8'h20, t0 + 3, t0 + 20, 1'b1);
    sb_push("en_ext_pin0", S_EXT,  8'h01, 8'h01, t0 + 1, t0 + 25, 1'b1);
    step(20);
    db_en = 8'h00;
    sb_push("en_ext",      S_EXT,  8'h20, 8'h20, t0 + 21, t0 + 21, 1'b1);
    sb_push("en_rise",     S_RISE, 8'h20, 8'h20, t0 + 21, t0 + 21, 1'b1);
    sb_push("en_rise_end", S_RISE, 8'h20, 8'h00, t0 + 22, t0 + 25, 1'b1);
    sb_push("en_busy_clr", S_BUSY, 8'h20, 8'h00, t0 + 21, t0 + 25, 1'b1);
    step(6);

    for (int k = 0; k < 200 && sb.size() > 0; k++) step(1);
    chk("sb_pending", 8'(sb.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
